// File: rtl/tag_free_list.sv
// Rename-tag free list: circular FIFO of free tags with alloc/free handshakes and flush recovery.
// Define TAG_FREE_LIST_CHECK_EN to add in-use tracking and the sticky err flag.
module tag_free_list #(
  parameter int TAG_W    = 4,
  parameter int NUM_TAGS = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             flush,
  output logic [CNT_W-1:0] free_cnt,
  output logic             empty,
  output logic             err
);

  logic [TAG_W-1:0] r_mem [NUM_TAGS];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_cnt;
  logic             r_empty;

  logic             w_gnt;
  logic             w_in_range;
  logic             w_full;
  logic             w_owned;
  logic             w_free_ok;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Pointers wrap at NUM_TAGS-1, which need not be a power of two.
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_in_range = (free_tag < TAG_W'(NUM_TAGS));
  assign w_full     = (r_cnt == CNT_W'(NUM_TAGS));
  assign w_gnt      = alloc_req & ~r_empty & ~flush & ~rst;
  assign w_free_ok  = free_en & ~flush & w_in_range & ~w_full & w_owned;

  assign alloc_gnt = w_gnt;
  assign alloc_tag = r_mem[r_head];
  assign free_cnt  = r_cnt;
  assign empty     = r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush)
      w_cnt_nxt = CNT_W'(NUM_TAGS);
    else if (w_gnt && !w_free_ok)
      w_cnt_nxt = r_cnt - 1'b1;
    else if (!w_gnt && w_free_ok)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++)
        r_mem[i] <= TAG_W'(i);
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= CNT_W'(NUM_TAGS);
      r_empty <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      if (flush) begin
        for (int i = 0; i < NUM_TAGS; i++)
          r_mem[i] <= TAG_W'(i);
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_gnt)
          r_head <= ptr_inc(r_head);
        if (w_free_ok) begin
          r_mem[r_tail] <= free_tag;
          r_tail        <= ptr_inc(r_tail);
        end
      end
    end
  end

`ifdef TAG_FREE_LIST_CHECK_EN
  logic [NUM_TAGS-1:0] r_in_use;
  logic                r_err;
  logic                w_bad;

  // A tag may only come back while it is held by the pipeline.
  assign w_owned = w_in_range & r_in_use[free_tag];
  assign w_bad   = free_en & ~flush & ~(w_in_range & ~w_full & w_owned);
  assign err     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_use <= '0;
      r_err    <= 1'b0;
    end else if (flush) begin
      r_in_use <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt)
        r_in_use[r_mem[r_head]] <= 1'b1;
      if (w_free_ok)
        r_in_use[free_tag] <= 1'b0;
      if (w_bad)
        r_err <= 1'b1;
    end
  end
`else
  assign w_owned = 1'b1;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// Directed and randomized bench for tag_free_list against a queue-based model of the free list.
module tb_tag_free_list;

`ifdef TAG_FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic       alloc_gnt;
  logic [3:0] alloc_tag;
  logic       free_en = 1'b0;
  logic [3:0] free_tag = '0;
  logic       flush = 1'b0;
  logic [3:0] free_cnt;
  logic       empty;
  logic       err;

  int n_chk = 0;
  int n_fail = 0;

  int q[$];
  bit inuse[NT];
  bit merr;

  tag_free_list #(.TAG_W(4), .NUM_TAGS(NT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .free_en(free_en), .free_tag(free_tag), .flush(flush),
    .free_cnt(free_cnt), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NT; i++) begin
      q.push_back(i);
      inuse[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cnt"}, 32'(free_cnt), 32'(q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".err"}, 32'(err), 32'(merr));
  endtask

  // One clock: drive at negedge, check outputs before the rising edge, then advance the model.
  task automatic step(input bit rq, input bit fe, input int ft, input bit fl);
    bit exp_gnt;
    bit ok;
    int t;
    @(negedge clk);
    alloc_req = rq;
    free_en   = fe;
    free_tag  = 4'(ft);
    flush     = fl;
    #1;
    exp_gnt = rq && (q.size() != 0) && !fl;
    check("gnt", 32'(alloc_gnt), 32'(exp_gnt));
    if (exp_gnt) check("tag", 32'(alloc_tag), 32'(q[0]));
    check_state("step");
    if (fl) begin
      model_reset();
    end else begin
      ok = fe && (ft < NT) && (q.size() < NT) && (!CHK || inuse[ft]);
      if (CHK && fe && !ok) merr = 1'b1;
      if (exp_gnt) begin
        t = q.pop_front();
        inuse[t] = 1'b1;
      end
      if (ok) begin
        q.push_back(ft);
        inuse[ft] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_req = 1'b1;
    free_en = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check("rst.gnt", 32'(alloc_gnt), 32'd0);
    check("rst.tag", 32'(alloc_tag), 32'd0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;
    alloc_req = 1'b0;
  endtask

  int ft;
  int off;

  initial begin
    model_reset();
    do_reset();

    // Drain all 15 tags, then one more request must be refused.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 0, 1'b0);
    // Free from empty: no bypass, grant arrives next cycle.
    step(1'b1, 1'b1, 7, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Tail wrap: alloc 0,1,2, return 1 then 0, drain everything.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 0, 1'b0);

    // Flush wins over alloc and free.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 2, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0);

    // Double free, then flush.
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);

    // Out-of-range / overflow free at the reset image.
    do_reset();
    step(1'b0, 1'b1, 15, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    // Random traffic with occasional flush and mid-sequence reset.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ft = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) begin
        off = $urandom_range(0, NT - 1);
        for (int k = 0; k < NT; k++) begin
          if (inuse[(off + k) % NT]) begin
            ft = (off + k) % NT;
            break;
          end
        end
      end
      if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), ft,
             1'($urandom_range(0, 59) == 0));
    end
    step(1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
